// File: rtl/core_fwd_pkg.sv
// rtl/core_fwd_pkg.sv - shared constants, operand record and helpers for the forwarding stage
`ifndef ALU_SRC_OP1_PC
`define ALU_SRC_OP1_PC 1'b1
`endif
`ifndef ALU_SRC_OP2_IMM
`define ALU_SRC_OP2_IMM 1'b1
`endif

package core_fwd_pkg;

  // Default configuration; the operand record below is sized from these.
  localparam int CFG_XLEN = 32;
  localparam int CFG_NSRC = 2;
  localparam int CFG_NSTG = 3;

  // Width of a bypass select able to name the register file plus every stage.
  function automatic int selw(input int nstg);
    return $clog2(nstg + 1);
  endfunction

  localparam int CFG_SELW = selw(CFG_NSTG);

  // Bypass-select encoding: 0 is the register file, stage k is k+1.
  localparam int BP_REGFILE = 0;

  function automatic int bp_stage(input int k);
    return k + 1;
  endfunction

  // Everything the issue register hands to execute for one instruction.
  typedef struct packed {
    logic [CFG_XLEN-1:0]                 op1;
    logic [CFG_XLEN-1:0]                 op2;
    logic [CFG_NSRC-1:0][CFG_XLEN-1:0]   bp;
    logic [CFG_NSRC-1:0][CFG_SELW-1:0]   bp_sel;
    logic [4:0]                          rd;
    logic                                rd_we;
  } operand_t;

endpackage

// File: rtl/core_exec_fwd_if.sv
// rtl/core_exec_fwd_if.sv - decode/forwarding/execute bundle for the issue stage
interface core_exec_fwd_if #(
  parameter int XLEN = core_fwd_pkg::CFG_XLEN,
  parameter int NSRC = core_fwd_pkg::CFG_NSRC,
  parameter int NSTG = core_fwd_pkg::CFG_NSTG,
  parameter int SELW = core_fwd_pkg::selw(NSTG)
) ();

  // Decode side
  logic                       i_flush;
  logic                       i_valid;
  logic                       o_ready;
  logic [NSRC-1:0][4:0]       i_rs;
  logic [NSRC-1:0][XLEN-1:0]  i_rs_val;
  logic                       i_alu_op1_sel;
  logic                       i_alu_op2_sel;
  logic [XLEN-3:0]            i_pc;
  logic [XLEN-1:0]            i_imm;
  logic [4:0]                 i_rd;
  logic                       i_rd_we;

  // In-flight producers, index 0 youngest
  logic [NSTG-1:0][4:0]       i_stg_rd;
  logic [NSTG-1:0]            i_stg_we;
  logic [NSTG-1:0][XLEN-1:0]  i_stg_val;
  logic [NSTG-1:0]            i_stg_rdy;

  // Execute side
  logic                       o_valid;
  logic                       i_ready;
  logic [XLEN-1:0]            o_op1;
  logic [XLEN-1:0]            o_op2;
  logic [NSRC-1:0][XLEN-1:0]  o_bp;
  logic [NSRC-1:0][SELW-1:0]  o_bp_sel;
  logic [4:0]                 o_rd;
  logic                       o_rd_we;
  logic [15:0]                o_stall_cnt;

  modport slave (
    input  i_flush, i_valid, i_rs, i_rs_val, i_alu_op1_sel, i_alu_op2_sel,
           i_pc, i_imm, i_rd, i_rd_we, i_stg_rd, i_stg_we, i_stg_val,
           i_stg_rdy, i_ready,
    output o_ready, o_valid, o_op1, o_op2, o_bp, o_bp_sel, o_rd, o_rd_we,
           o_stall_cnt
  );

  modport master (
    output i_flush, i_valid, i_rs, i_rs_val, i_alu_op1_sel, i_alu_op2_sel,
           i_pc, i_imm, i_rd, i_rd_we, i_stg_rd, i_stg_we, i_stg_val,
           i_stg_rdy, i_ready,
    input  o_ready, o_valid, o_op1, o_op2, o_bp, o_bp_sel, o_rd, o_rd_we,
           o_stall_cnt
  );

endinterface

// File: rtl/core_fwd_sel.sv
// rtl/core_fwd_sel.sv - youngest-producer bypass match for a single source operand
module core_fwd_sel
  import core_fwd_pkg::*;
#(
  parameter int XLEN = CFG_XLEN,
  parameter int NSTG = CFG_NSTG,
  parameter int SELW = selw(NSTG)
) (
  input  logic [4:0]                i_rs,
  input  logic [XLEN-1:0]           i_rs_val,
  input  logic [NSTG-1:0][4:0]      i_stg_rd,
  input  logic [NSTG-1:0]           i_stg_we,
  input  logic [NSTG-1:0][XLEN-1:0] i_stg_val,
  input  logic [NSTG-1:0]           i_stg_rdy,
  output logic [XLEN-1:0]           o_val,
  output logic [SELW-1:0]           o_sel,
  output logic                      o_hazard
);

  // Scan oldest to youngest so the youngest hit is the one that sticks; only
  // that stage's readiness matters, older ready copies are stale.
  always_comb begin
    o_val    = i_rs_val;
    o_sel    = SELW'(BP_REGFILE);
    o_hazard = 1'b0;
    if (i_rs == 5'd0) begin
      o_val = '0;
    end else begin
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (i_stg_we[k] && (i_stg_rd[k] == i_rs)) begin
          o_val    = i_stg_val[k];
          o_sel    = SELW'(bp_stage(k));
          o_hazard = !i_stg_rdy[k];
        end
      end
    end
  end

endmodule

// File: rtl/core_exec_fwd.sv
// rtl/core_exec_fwd.sv - operand forwarding and issue register between decode and execute
module core_exec_fwd
  import core_fwd_pkg::*;
#(
  parameter int XLEN = CFG_XLEN,
  parameter int NSRC = CFG_NSRC,
  parameter int NSTG = CFG_NSTG,
  parameter int SELW = selw(NSTG)
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  core_exec_fwd_if.slave bus
);

  // The operand record is sized from the package defaults, so the parameters
  // here are expected to keep those values.
  logic [NSRC-1:0][XLEN-1:0] w_val;
  logic [NSRC-1:0][SELW-1:0] w_sel;
  logic [NSRC-1:0]           w_hazard_src;
  logic                      w_hazard;
  logic                      w_ready;
  logic                      w_accept;
  operand_t                  w_next;

  operand_t                  r_out;
  logic                      r_valid;
  logic [15:0]               r_stall_cnt;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    core_fwd_sel #(
      .XLEN (XLEN),
      .NSTG (NSTG),
      .SELW (SELW)
    ) u_sel (
      .i_rs      (bus.i_rs[s]),
      .i_rs_val  (bus.i_rs_val[s]),
      .i_stg_rd  (bus.i_stg_rd),
      .i_stg_we  (bus.i_stg_we),
      .i_stg_val (bus.i_stg_val),
      .i_stg_rdy (bus.i_stg_rdy),
      .o_val     (w_val[s]),
      .o_sel     (w_sel[s]),
      .o_hazard  (w_hazard_src[s])
    );
  end

  assign w_hazard = |w_hazard_src;
  assign w_ready  = !w_hazard && (!r_valid || bus.i_ready) && !bus.i_flush;
  assign w_accept = bus.i_valid && w_ready;

  // Build the record to capture: ALU operand muxing plus raw forwarded values
  always_comb begin
    w_next        = '0;
    w_next.op1    = (bus.i_alu_op1_sel == `ALU_SRC_OP1_PC) ? {bus.i_pc, 2'b00} : w_val[0];
    w_next.op2    = (bus.i_alu_op2_sel == `ALU_SRC_OP2_IMM) ? bus.i_imm : w_val[1];
    w_next.bp     = w_val;
    w_next.bp_sel = w_sel;
    w_next.rd     = bus.i_rd;
    w_next.rd_we  = bus.i_rd_we;
  end

  // Issue register: flush kills, accept loads, consume drains, otherwise hold
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else if (bus.i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_out   <= w_next;
    end else if (r_valid && bus.i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating count of cycles decode was held back by a load-use hazard
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_cnt <= '0;
    end else if (bus.i_valid && w_hazard && !bus.i_flush && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_valid     = r_valid;
  assign bus.o_op1       = r_out.op1;
  assign bus.o_op2       = r_out.op2;
  assign bus.o_bp        = r_out.bp;
  assign bus.o_bp_sel    = r_out.bp_sel;
  assign bus.o_rd        = r_out.rd;
  assign bus.o_rd_we     = r_out.rd_we;
  assign bus.o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_core_exec_fwd.sv
// tb/tb_core_exec_fwd.sv - directed and randomized checks of core_exec_fwd against a reference model
module tb_core_exec_fwd;
  import core_fwd_pkg::*;

  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int NSTG = 3;
  localparam int SELW = selw(NSTG);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  core_exec_fwd_if #(.XLEN(XLEN), .NSRC(NSRC), .NSTG(NSTG), .SELW(SELW)) bus ();

  core_exec_fwd #(.XLEN(XLEN), .NSRC(NSRC), .NSTG(NSTG), .SELW(SELW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial forever #5 clk = ~clk;

  // Reference state: what execute should currently be seeing
  logic        m_valid;
  logic [31:0] m_op1, m_op2;
  logic [31:0] m_bp  [NSRC];
  int          m_sel [NSRC];
  logic [4:0]  m_rd;
  logic        m_rd_we;
  int          m_cnt;

  // Reference combinational view of the current inputs
  logic        e_hazard, e_ready;
  logic [31:0] e_val [NSRC];
  int          e_sel [NSRC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_rd_we = 1'b0; m_cnt = 0;
    for (int s = 0; s < NSRC; s++) begin m_bp[s] = '0; m_sel[s] = 0; end
  endtask

  // First matching stage from youngest wins; x0 is hard-wired zero
  task automatic model_eval();
    bit found;
    e_hazard = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      e_val[s] = bus.i_rs_val[s];
      e_sel[s] = 0;
      found    = 0;
      if (bus.i_rs[s] == 0) begin
        e_val[s] = 0;
      end else begin
        for (int k = 0; k < NSTG; k++) begin
          if (!found && bus.i_stg_we[k] && bus.i_stg_rd[k] == bus.i_rs[s]) begin
            found    = 1;
            e_val[s] = bus.i_stg_val[k];
            e_sel[s] = k + 1;
            if (!bus.i_stg_rdy[k]) e_hazard = 1'b1;
          end
        end
      end
    end
    e_ready = !e_hazard && (!m_valid || bus.i_ready) && !bus.i_flush;
  endtask

  task automatic check_outputs();
    chk("o_valid", bus.o_valid, m_valid);
    chk("o_op1", bus.o_op1, m_op1);
    chk("o_op2", bus.o_op2, m_op2);
    for (int s = 0; s < NSRC; s++) begin
      chk($sformatf("o_bp[%0d]", s), bus.o_bp[s], m_bp[s]);
      chk($sformatf("o_bp_sel[%0d]", s), bus.o_bp_sel[s], m_sel[s]);
    end
    chk("o_rd", bus.o_rd, m_rd);
    chk("o_rd_we", bus.o_rd_we, m_rd_we);
    chk("o_stall_cnt", bus.o_stall_cnt, m_cnt);
  endtask

  // Called at a falling edge with inputs already driven; ends at the next falling edge
  task automatic cyc();
    #1;
    model_eval();
    chk("o_ready", bus.o_ready, e_ready);
    @(posedge clk);
    if (bus.i_valid && e_hazard && !bus.i_flush && m_cnt < 65535) m_cnt++;
    if (bus.i_flush) begin
      m_valid = 1'b0;
    end else if (bus.i_valid && e_ready) begin
      m_valid = 1'b1;
      m_op1   = bus.i_alu_op1_sel ? {bus.i_pc, 2'b00} : e_val[0];
      m_op2   = bus.i_alu_op2_sel ? bus.i_imm : e_val[1];
      for (int s = 0; s < NSRC; s++) begin m_bp[s] = e_val[s]; m_sel[s] = e_sel[s]; end
      m_rd    = bus.i_rd;
      m_rd_we = bus.i_rd_we;
    end else if (m_valid && bus.i_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.i_flush = 0; bus.i_valid = 0; bus.i_ready = 1;
    bus.i_alu_op1_sel = 0; bus.i_alu_op2_sel = 0; bus.i_pc = '0; bus.i_imm = '0;
    bus.i_rd = 5'd0; bus.i_rd_we = 0;
    for (int s = 0; s < NSRC; s++) begin bus.i_rs[s] = '0; bus.i_rs_val[s] = '0; end
    for (int k = 0; k < NSTG; k++) begin
      bus.i_stg_rd[k] = '0; bus.i_stg_we[k] = 0; bus.i_stg_val[k] = '0; bus.i_stg_rdy[k] = 1;
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // No match: register-file values flow through
    bus.i_valid = 1; bus.i_rs[0] = 5; bus.i_rs[1] = 6;
    bus.i_rs_val[0] = 32'h11; bus.i_rs_val[1] = 32'h22; bus.i_rd = 7; bus.i_rd_we = 1;
    cyc();
    chk("nomatch_valid", bus.o_valid, 1);
    chk("nomatch_op1", bus.o_op1, 32'h11);
    chk("nomatch_op2", bus.o_op2, 32'h22);
    chk("nomatch_sel0", bus.o_bp_sel[0], 0);

    // Priority: youngest stage wins over an older writer of the same register
    bus.i_stg_rd[0] = 5; bus.i_stg_we[0] = 1; bus.i_stg_val[0] = 32'hAAAA;
    bus.i_stg_rd[2] = 5; bus.i_stg_we[2] = 1; bus.i_stg_val[2] = 32'hBBBB;
    cyc();
    chk("prio_bp0", bus.o_bp[0], 32'hAAAA);
    chk("prio_sel0", bus.o_bp_sel[0], 1);

    // x0 never forwards
    bus.i_rs[0] = 0; bus.i_stg_rd[0] = 0; bus.i_stg_rd[2] = 0;
    cyc();
    chk("x0_bp0", bus.o_bp[0], 0);
    chk("x0_sel0", bus.o_bp_sel[0], 0);

    // Load-use: young producer not ready holds decode for two cycles
    bus.i_stg_we[2] = 0;
    bus.i_rs[0] = 5; bus.i_stg_rd[0] = 5; bus.i_stg_we[0] = 1; bus.i_stg_rdy[0] = 0;
    bus.i_stg_val[0] = 32'hDEAD;
    repeat (2) begin
      #1 chk("loaduse_ready", bus.o_ready, 0);
      #1 cyc();
    end
    chk("loaduse_cnt", bus.o_stall_cnt, 2);
    bus.i_stg_rdy[0] = 1; bus.i_stg_val[0] = 32'h1234;
    cyc();
    chk("loaduse_bp0", bus.o_bp[0], 32'h1234);
    chk("loaduse_valid", bus.o_valid, 1);

    // Back-pressure: held instruction stays put, new one waits
    bus.i_stg_we[0] = 0; bus.i_ready = 0;
    bus.i_rs_val[0] = 32'h77; bus.i_rs_val[1] = 32'h88;
    repeat (3) begin
      cyc();
      chk("bp_hold_bp0", bus.o_bp[0], 32'h1234);
      chk("bp_hold_valid", bus.o_valid, 1);
    end
    bus.i_ready = 1;
    cyc();
    chk("bp_release_op1", bus.o_op1, 32'h77);
    chk("bp_release_op2", bus.o_op2, 32'h88);

    // Flush beats a simultaneous accept; old contents stay
    bus.i_flush = 1; bus.i_rs_val[0] = 32'h99;
    cyc();
    chk("flush_valid", bus.o_valid, 0);
    chk("flush_op1", bus.o_op1, 32'h77);
    bus.i_flush = 0;

    // Operand muxing: PC/IMM replace op1/op2, o_bp keeps forwarded values
    bus.i_alu_op1_sel = 1; bus.i_pc = 30'h40;
    bus.i_alu_op2_sel = 1; bus.i_imm = 32'hFFFF_FFF0;
    bus.i_rs_val[0] = 32'h55;
    bus.i_stg_rd[1] = 6; bus.i_stg_we[1] = 1; bus.i_stg_val[1] = 32'h66;
    cyc();
    chk("mux_op1", bus.o_op1, 32'h100);
    chk("mux_op2", bus.o_op2, 32'hFFFF_FFF0);
    chk("mux_bp0", bus.o_bp[0], 32'h55);
    chk("mux_bp1", bus.o_bp[1], 32'h66);
    chk("mux_sel1", bus.o_bp_sel[1], 2);

    // Randomized traffic with a narrow register range to provoke matches
    for (int n = 0; n < 300; n++) begin
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      bus.i_flush = ($urandom_range(0, 15) == 0);
      bus.i_alu_op1_sel = $urandom_range(0, 1);
      bus.i_alu_op2_sel = $urandom_range(0, 1);
      bus.i_pc = 30'($urandom); bus.i_imm = $urandom;
      bus.i_rd = 5'($urandom); bus.i_rd_we = $urandom_range(0, 1);
      for (int s = 0; s < NSRC; s++) begin
        bus.i_rs[s] = 5'($urandom_range(0, 7)); bus.i_rs_val[s] = $urandom;
      end
      for (int k = 0; k < NSTG; k++) begin
        bus.i_stg_rd[k]  = 5'($urandom_range(0, 7));
        bus.i_stg_we[k]  = $urandom_range(0, 1);
        bus.i_stg_val[k] = $urandom;
        bus.i_stg_rdy[k] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end

    // Asynchronous reset mid-stream clears everything without an edge
    drive_idle();
    bus.i_valid = 1; bus.i_rs[0] = 3; bus.i_rs_val[0] = 32'hCAFE; bus.i_rd = 9; bus.i_rd_we = 1;
    cyc();
    chk("pre_reset_valid", bus.o_valid, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("reset_bp0", bus.o_bp[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
